mips_instr_encoder: RTL and testbench
=====================================

# mips_instr_encoder

Streaming MIPS instruction encoder and program loader: the inverse of `control_unit`. It accepts compact instruction descriptors (operation code, register fields, immediate) over a valid/ready handshake. For each descriptor it assembles the 32-bit MIPS word using the same opcode/funct map that `control_unit` decodes, then writes the words to consecutive instruction-memory addresses. It sits between the test/boot host and the I-cache backing memory, and is used to load programs before the pipeline is released from reset.

## Interface
- `ADDR_W`, 10, word-address width of instruction memory
- `BASE_ADDR`, 0, first word address written after `start`

- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `start`  in  1  begin a load session (honoured only in IDLE or DONE)
- `in_valid`  in  1  descriptor valid
- `in_ready`  out  1  descriptor accepted when `in_valid && in_ready`
- `in_op`  in  4  operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SLL, 8 SRL, 9 LW, 10 SW, 11 BEQ, 12 J, 13 ADDI, 14 NOP, 15 illegal
- `in_rs`, `in_rt`, `in_rd`, `in_shamt`  in  5 each  register and shift fields
- `in_imm`  in  26  [15:0] for I-type, [25:0] for J
- `in_last`  in  1  marks the final descriptor of the session
- `mem_we`  out  1  write request, held until `mem_ready`
- `mem_addr`  out  ADDR_W  word address
- `mem_wdata`  out  32  encoded instruction
- `mem_ready`  in  1  memory accepts the write this cycle
- `busy`  out  1  state is RUN
- `done`  out  1  state is DONE
- `err`  out  1  sticky error: illegal op or address wrap
- `count`  out  ADDR_W+1  number of words written this session

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on `start`.
  - RUN → DONE on the cycle the write of the `in_last` word completes (`mem_we && mem_ready`).
  - DONE → RUN on `start`.
- Effects of `start`:
  - Set the address pointer to BASE_ADDR.
  - Clear `count` and `err`.
  - `start` is ignored in RUN.
- Encoding:
  - R-type (ADD, SUB, AND, OR, XOR, NOR, SLT): {6'h00, rs, rt, rd, 5'd0, funct}. Funct values are 0x20, 0x22, 0x24, 0x25, 0x26, 0x27, 0x2A respectively.
  - SLL / SRL: {6'h00, 5'd0, rt, rd, shamt, 6'h00 / 6'h02}.
  - LW 0x23, SW 0x2B, BEQ 0x04, ADDI 0x08: {op, rs, rt, imm[15:0]}.
  - J: {6'h02, imm[25:0]}.
  - NOP: 32'h0000_0000.
  - Illegal op (15): encodes as NOP and sets `err`. The word is still written and counted.
- Output stage is a single register holding `mem_wdata`, `mem_addr`, `mem_we` and a registered last flag.
  - `in_ready` = RUN && (!mem_we || mem_ready).
  - This gives full throughput under continuous `mem_ready`.
- On each completed write:
  - The pointer increments.
  - `count` increments.
- The pointer wraps from 2^ADDR_W−1 to 0. A wrap sets `err` and loading continues.
- No descriptor is accepted after `in_last` until the next `start`.

## Timing
- Reset values: state IDLE; `in_ready`, `mem_we`, `busy`, `done`, `err` = 0; `mem_addr`, `mem_wdata`, `count` = 0.
- `rst_n` low mid-session aborts immediately. A pending write is dropped, with no partial hold.
- Latency: a descriptor accepted at edge N appears on `mem_we`/`mem_wdata` after edge N.
- While `mem_we` is high and `mem_ready` is low, `mem_addr` and `mem_wdata` stay stable.
- Accept and write-complete in the same cycle: the new word replaces the old one, `mem_we` stays high, and the address advances by 1.
- `done` rises in the cycle after the last write completes.
- `count` is final when `done` = 1.

## Structure
- Shared package `mips_isa_pkg` holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI);
  - funct constants (FN_ADD … FN_SRL);
  - the `in_op` enumeration.
- `control_unit` is to migrate to the same constants.
- One combinational sub-module, `mips_instr_pack` (descriptor → {word, illegal}), keeps the encoding separately testable against `control_unit`.
- FSM, pointer and output register stay in the top.

## Test plan
- ADD rs=1 rt=2 rd=3 after `start`, `mem_ready`=1 → `mem_wdata`=0x00221820 at `mem_addr`=0, next cycle.
- LW rs=29 rt=8 imm=4; SLL rt=1 rd=2 shamt=4 → 0x8FA80004 and 0x00011100 at addresses 0 and 1.
- BEQ rs=4 rt=5 imm=0xFFFF; J imm=0x0100000 with `in_last` → 0x1085FFFF and 0x08100000, then `done`=1 and `count`=2.
- `mem_ready` held low 3 cycles during a write → `mem_we`, `mem_addr`, `mem_wdata` stable, `in_ready`=0; then 1-per-cycle streaming resumes.
- `in_op`=15 → word 0x00000000 written, `err`=1 until next `start`.
- ADDR_W=2, BASE_ADDR=3, two words → addresses 3 then 0 and `err`=1.
- `rst_n` low mid-stream → all outputs 0, state IDLE.

Source files
------------

// File: rtl/mips_isa_pkg.sv
// mips_isa_pkg: the MIPS opcode/funct map shared by the instruction encoder
// and the control_unit decoder, plus the compact operation enumeration used
// on the encoder's descriptor input.
package mips_isa_pkg;

  // Primary opcodes, bits [31:26]
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes, bits [5:0]
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // Descriptor operation codes
  typedef enum logic [3:0] {
    IOP_ADD     = 4'd0,
    IOP_SUB     = 4'd1,
    IOP_AND     = 4'd2,
    IOP_OR      = 4'd3,
    IOP_XOR     = 4'd4,
    IOP_NOR     = 4'd5,
    IOP_SLT     = 4'd6,
    IOP_SLL     = 4'd7,
    IOP_SRL     = 4'd8,
    IOP_LW      = 4'd9,
    IOP_SW      = 4'd10,
    IOP_BEQ     = 4'd11,
    IOP_J       = 4'd12,
    IOP_ADDI    = 4'd13,
    IOP_NOP     = 4'd14,
    IOP_ILLEGAL = 4'd15
  } instr_op_e;

  // Assemble an R-type word
  function automatic logic [31:0] pack_rtype(input logic [4:0] rs, input logic [4:0] rt,
                                             input logic [4:0] rd, input logic [4:0] shamt,
                                             input logic [5:0] fn);
    return {OP_RTYPE, rs, rt, rd, shamt, fn};
  endfunction

endpackage

// File: rtl/mips_instr_pack.sv
// mips_instr_pack: purely combinational descriptor -> 32-bit MIPS word.
// Ports:
//   i_op, i_rs, i_rt, i_rd, i_shamt, i_imm : descriptor fields
//   o_word    : encoded instruction (NOP for an illegal op)
//   o_illegal : high when i_op is not a defined operation
module mips_instr_pack
  import mips_isa_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [4:0]  i_rs,
  input  logic [4:0]  i_rt,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_shamt,
  input  logic [25:0] i_imm,
  output logic [31:0] o_word,
  output logic        o_illegal
);

  always_comb begin
    o_word    = 32'h0000_0000;
    o_illegal = 1'b0;
    case (instr_op_e'(i_op))
      IOP_ADD:  o_word = pack_rtype(i_rs, i_rt, i_rd, 5'd0, FN_ADD);
      IOP_SUB:  o_word = pack_rtype(i_rs, i_rt, i_rd, 5'd0, FN_SUB);
      IOP_AND:  o_word = pack_rtype(i_rs, i_rt, i_rd, 5'd0, FN_AND);
      IOP_OR:   o_word = pack_rtype(i_rs, i_rt, i_rd, 5'd0, FN_OR);
      IOP_XOR:  o_word = pack_rtype(i_rs, i_rt, i_rd, 5'd0, FN_XOR);
      IOP_NOR:  o_word = pack_rtype(i_rs, i_rt, i_rd, 5'd0, FN_NOR);
      IOP_SLT:  o_word = pack_rtype(i_rs, i_rt, i_rd, 5'd0, FN_SLT);
      // Shifts take their operand from rt; rs is forced to zero
      IOP_SLL:  o_word = pack_rtype(5'd0, i_rt, i_rd, i_shamt, FN_SLL);
      IOP_SRL:  o_word = pack_rtype(5'd0, i_rt, i_rd, i_shamt, FN_SRL);
      IOP_LW:   o_word = {OP_LW,   i_rs, i_rt, i_imm[15:0]};
      IOP_SW:   o_word = {OP_SW,   i_rs, i_rt, i_imm[15:0]};
      IOP_BEQ:  o_word = {OP_BEQ,  i_rs, i_rt, i_imm[15:0]};
      IOP_ADDI: o_word = {OP_ADDI, i_rs, i_rt, i_imm[15:0]};
      IOP_J:    o_word = {OP_J, i_imm};
      IOP_NOP:  o_word = 32'h0000_0000;
      default:  o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_instr_encoder.sv
// mips_instr_encoder: streaming instruction encoder / program loader.
// Accepts descriptors over valid/ready, encodes them and writes the words to
// consecutive instruction-memory addresses starting at BASE_ADDR.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   start             : begin a session (IDLE or DONE only)
//   in_valid/in_ready : descriptor handshake; in_op/rs/rt/rd/shamt/imm/last
//   mem_we/mem_addr/mem_wdata/mem_ready : write port, held until accepted
//   busy, done        : state RUN / state DONE
//   err               : sticky illegal-op or address-wrap flag
//   count             : words written this session
module mips_instr_encoder
  import mips_isa_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [25:0]       in_imm,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   count
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  localparam logic [ADDR_W-1:0] LP_BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LP_MAX  = '1;

  state_e            r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [31:0]       r_wdata;
  logic              r_we;
  logic              r_last;       // word in the output register is the session's last
  logic              r_seen_last;  // last descriptor already accepted
  logic              r_err;
  logic [ADDR_W:0]   r_count;

  logic [31:0]       w_word;
  logic              w_illegal;
  logic              w_ready;
  logic              w_accept;
  logic              w_complete;

  mips_instr_pack u_pack (
    .i_op      (in_op),
    .i_rs      (in_rs),
    .i_rt      (in_rt),
    .i_rd      (in_rd),
    .i_shamt   (in_shamt),
    .i_imm     (in_imm),
    .o_word    (w_word),
    .o_illegal (w_illegal)
  );

  // The output register can take a new word when empty or when its current
  // word is leaving this cycle.
  assign w_ready    = (r_state == S_RUN) && !r_seen_last && (!r_we || mem_ready);
  assign w_accept   = in_valid && w_ready;
  assign w_complete = r_we && mem_ready;

  // The pointer always names the address of the word in the output register
  // (or of the next one), so it drives mem_addr directly and only advances
  // when a write completes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_wdata     <= '0;
      r_we        <= 1'b0;
      r_last      <= 1'b0;
      r_seen_last <= 1'b0;
      r_err       <= 1'b0;
      r_count     <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state     <= S_RUN;
            r_ptr       <= LP_BASE;
            r_count     <= '0;
            r_err       <= 1'b0;
            r_seen_last <= 1'b0;
            r_we        <= 1'b0;
            r_last      <= 1'b0;
          end
        end
        S_RUN: begin
          if (w_complete) begin
            r_ptr   <= r_ptr + 1'b1;
            r_count <= r_count + 1'b1;
            if (r_ptr == LP_MAX) r_err <= 1'b1;
            if (r_last) r_state <= S_DONE;
          end
          if (w_accept) begin
            r_we    <= 1'b1;
            r_wdata <= w_word;
            r_last  <= in_last;
            if (in_last) r_seen_last <= 1'b1;
            if (w_illegal) r_err <= 1'b1;
          end else if (w_complete) begin
            r_we <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = w_ready;
  assign mem_we    = r_we;
  assign mem_addr  = r_ptr;
  assign mem_wdata = r_wdata;
  assign busy      = (r_state == S_RUN);
  assign done      = (r_state == S_DONE);
  assign err       = r_err;
  assign count     = r_count;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Scoreboard bench for mips_instr_encoder: directed test-plan cases plus
// randomized sessions checked against a field-arithmetic reference model.
module tb_mips_instr_encoder;

  localparam int AW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start, in_valid, in_ready, in_last;
  logic [3:0]    in_op;
  logic [4:0]    in_rs, in_rt, in_rd, in_shamt;
  logic [25:0]   in_imm;
  logic          mem_we, mem_ready, busy, done, err;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [AW:0]   count;

  logic          start2, in_valid2, in_ready2, mem_we2, mem_ready2, busy2, done2, err2;
  logic [1:0]    mem_addr2;
  logic [31:0]   mem_wdata2;
  logic [2:0]    count2;

  mips_instr_encoder #(.ADDR_W(AW), .BASE_ADDR(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_imm(in_imm), .in_last(in_last), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .busy(busy), .done(done), .err(err),
    .count(count)
  );

  mips_instr_encoder #(.ADDR_W(2), .BASE_ADDR(3)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_imm(in_imm), .in_last(in_last), .mem_we(mem_we2), .mem_addr(mem_addr2),
    .mem_wdata(mem_wdata2), .mem_ready(mem_ready2), .busy(busy2), .done(done2), .err(err2),
    .count(count2)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   word;
  } exp_t;
  exp_t sbq[$];

  int rdy_mode;      // 0: always ready, 1: random, 2: held low
  int exp_ptr;
  int exp_cnt;
  bit exp_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Reference encoder from the ISA field layout, plain arithmetic
  function automatic logic [31:0] ref_word(input int op, input int rs, input int rt,
                                           input int rd, input int sh, input int imm);
    int     fn[7] = '{32, 34, 36, 37, 38, 39, 42};
    longint w;
    longint opc;
    w = 0;
    if (op <= 6) begin
      w = longint'(rs) * 2097152 + longint'(rt) * 65536 + longint'(rd) * 2048 + fn[op];
    end else if (op == 7 || op == 8) begin
      w = longint'(rt) * 65536 + longint'(rd) * 2048 + longint'(sh) * 64 + ((op == 8) ? 2 : 0);
    end else if (op == 9 || op == 10 || op == 11 || op == 13) begin
      opc = (op == 9) ? 35 : (op == 10) ? 43 : (op == 11) ? 4 : 8;
      w = opc * 67108864 + longint'(rs) * 2097152 + longint'(rt) * 65536 + (imm % 65536);
    end else if (op == 12) begin
      w = 2 * 67108864 + (imm % 67108864);
    end
    return 32'(w);
  endfunction

  // mem_ready driver, changes just after each rising edge
  initial begin
    mem_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       mem_ready = 1'b1;
        1:       mem_ready = ($urandom_range(0, 3) != 0);
        default: mem_ready = 1'b0;
      endcase
    end
  end

  // Monitor: every write that completes at the coming edge must match the queue head
  always @(negedge clk) begin
    if (rst_n && mem_we && mem_ready) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr %0h data %0h want no write", mem_addr, mem_wdata);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("wr_addr", 64'(mem_addr), 64'(e.addr));
        check("wr_data", 64'(mem_wdata), 64'(e.word));
      end
    end
  end

  // Present one descriptor, wait for acceptance, update the model
  task automatic send(input int op, input int rs, input int rt, input int rd, input int sh,
                      input int imm, input bit last, input logic [31:0] word, output int waited);
    exp_t e;
    waited = 0;
    in_op = op[3:0]; in_rs = rs[4:0]; in_rt = rt[4:0]; in_rd = rd[4:0];
    in_shamt = sh[4:0]; in_imm = imm[25:0]; in_last = last; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 200) begin
        total++;
        bad++;
        $display("FAIL accept_timeout: got in_ready 0 want 1 within 200 cycles");
        in_valid = 1'b0;
        in_last  = 1'b0;
        return;
      end
    end
    e.addr = exp_ptr[AW-1:0];
    e.word = word;
    sbq.push_back(e);
    if (exp_ptr == (1 << AW) - 1) exp_err = 1'b1;
    exp_ptr = (exp_ptr + 1) % (1 << AW);
    exp_cnt++;
    if (op == 15) exp_err = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic begin_session();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    exp_ptr = 0;
    exp_cnt = 0;
    exp_err = 1'b0;
    check("busy_after_start", 64'(busy), 64'(1));
    check("err_after_start", 64'(err), 64'(0));
  endtask

  task automatic finish_session();
    int n;
    n = 0;
    @(negedge clk);
    check("no_accept_after_last", 64'(in_ready), 64'(0));
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("done", 64'(done), 64'(1));
    check("count", 64'(count), 64'(exp_cnt));
    check("err", 64'(err), 64'(exp_err));
    check("sb_empty", 64'(sbq.size()), 64'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int a0;
    logic [31:0] d0;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0; in_imm = '0;
    start2 = 1'b0; in_valid2 = 1'b0; mem_ready2 = 1'b1;
    rdy_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_mem_we", 64'(mem_we), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    check("rst_addr", 64'(mem_addr), 64'(0));
    check("rst_wdata", 64'(mem_wdata), 64'(0));
    check("rst_count", 64'(count), 64'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ADD rs=1 rt=2 rd=3
    begin_session();
    send(0, 1, 2, 3, 0, 0, 1'b1, 32'h0022_1820, w);
    check("add_wdata_next_cycle", 64'(mem_wdata), 64'h0022_1820);
    check("add_addr_next_cycle", 64'(mem_addr), 64'(0));
    finish_session();

    // LW then SLL
    begin_session();
    send(9, 29, 8, 0, 0, 4, 1'b0, 32'h8FA8_0004, w);
    send(7, 0, 1, 2, 4, 0, 1'b1, 32'h0001_1100, w);
    finish_session();

    // BEQ then J with in_last
    begin_session();
    send(11, 4, 5, 0, 0, 16'hFFFF, 1'b0, 32'h1085_FFFF, w);
    send(12, 0, 0, 0, 0, 26'h010_0000, 1'b1, 32'h0810_0000, w);
    finish_session();

    // Back-pressure: mem_ready low for 3 cycles, then full-rate streaming
    rdy_mode = 2;
    begin_session();
    @(posedge clk);
    #1;
    send(1, 7, 8, 9, 0, 0, 1'b0, ref_word(1, 7, 8, 9, 0, 0), w);
    a0 = int'(mem_addr);
    d0 = mem_wdata;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_we", 64'(mem_we), 64'(1));
      check("stall_addr", 64'(mem_addr), 64'(a0));
      check("stall_wdata", 64'(mem_wdata), 64'(d0));
      check("stall_in_ready", 64'(in_ready), 64'(0));
    end
    rdy_mode = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      send(i, i + 1, i + 2, i + 3, 0, 0, (i == 3), ref_word(i, i + 1, i + 2, i + 3, 0, 0), w);
      check("stream_no_stall", 64'(w), 64'(0));
    end
    finish_session();

    // Illegal op: NOP written, err sticky until next start
    begin_session();
    send(13, 3, 4, 0, 0, 26'h3_1234, 1'b0, ref_word(13, 3, 4, 0, 0, 26'h3_1234), w);
    send(15, 9, 9, 9, 9, 26'h3FF_FFFF, 1'b0, 32'h0000_0000, w);
    send(4, 10, 11, 12, 0, 0, 1'b1, ref_word(4, 10, 11, 12, 0, 0), w);
    finish_session();
    repeat (3) @(posedge clk);
    #1;
    check("err_sticky", 64'(err), 64'(1));

    // Randomized sessions, some long enough to wrap the 16-word space
    for (int s = 0; s < 8; s++) begin
      int n;
      rdy_mode = (s % 3 == 0) ? 0 : 1;
      n = $urandom_range(3, 22);
      begin_session();
      for (int i = 0; i < n; i++) begin
        int op, rs, rt, rd, sh, imm;
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
        op  = $urandom_range(0, 15);
        rs  = $urandom_range(0, 31);
        rt  = $urandom_range(0, 31);
        rd  = $urandom_range(0, 31);
        sh  = $urandom_range(0, 31);
        imm = int'($urandom() & 32'h03FF_FFFF);
        send(op, rs, rt, rd, sh, imm, (i == n - 1), ref_word(op, rs, rt, rd, sh, imm), w);
      end
      finish_session();
    end
    rdy_mode = 0;

    // Small instance: ADDR_W=2, BASE_ADDR=3, two words wrap 3 -> 0
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    check("w2_ready", 64'(in_ready2), 64'(1));
    in_op = 4'd13; in_rs = 5'd1; in_rt = 5'd2; in_imm = 26'd5; in_last = 1'b0; in_valid2 = 1'b1;
    @(posedge clk);
    #1;
    check("w2_addr0", 64'(mem_addr2), 64'(3));
    check("w2_data0", 64'(mem_wdata2), 64'h2022_0005);
    check("w2_ready1", 64'(in_ready2), 64'(1));
    in_op = 4'd14; in_last = 1'b1;
    @(posedge clk);
    #1;
    in_valid2 = 1'b0; in_last = 1'b0;
    check("w2_addr1", 64'(mem_addr2), 64'(0));
    check("w2_data1", 64'(mem_wdata2), 64'h0000_0000);
    check("w2_wrap_err", 64'(err2), 64'(1));
    @(posedge clk);
    #1;
    check("w2_done", 64'(done2), 64'(1));
    check("w2_count", 64'(count2), 64'(2));
    check("w2_err_final", 64'(err2), 64'(1));

    // Reset in the middle of a stalled write
    rdy_mode = 2;
    begin_session();
    @(posedge clk);
    #1;
    send(2, 1, 1, 1, 0, 0, 1'b0, ref_word(2, 1, 1, 1, 0, 0), w);
    check("pre_rst_we", 64'(mem_we), 64'(1));
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    sbq.delete();
    check("mid_rst_we", 64'(mem_we), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_done", 64'(done), 64'(0));
    check("mid_rst_err", 64'(err), 64'(0));
    check("mid_rst_addr", 64'(mem_addr), 64'(0));
    check("mid_rst_wdata", 64'(mem_wdata), 64'(0));
    check("mid_rst_count", 64'(count), 64'(0));
    check("mid_rst_in_ready", 64'(in_ready), 64'(0));
    rst_n = 1'b1;
    rdy_mode = 0;
    @(posedge clk);
    #1;
    check("idle_after_rst", 64'(busy), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
